id_ex_elastic: RTL

- Parametrised successor of the ID/EX pipeline register: elastic valid/ready stage between decode and execute.
- Carries LANES decode slots (single- or dual-issue) and an optional skid entry, so ID can deassert-free hand over while EX backpressures.
- Handles flush, the legacy stall input, delay-slot propagation and a saturating backpressure counter for perf monitoring.

---
 rtl/id_ex_elastic_pkg.sv | 23 ++
 rtl/id_ex_slot.sv | 30 +++
 rtl/id_ex_elastic.sv | 114 +++++++++++
 3 files changed

// File: rtl/id_ex_elastic_pkg.sv
// Shared widths, NOP encodings and payload packing helpers for the ID/EX elastic stage.
// Payload layout, MSB first: aluop, alusel, reg1, reg2, wd, wreg, link_addr, inst, delay-slot flag.
package id_ex_elastic_pkg;

  localparam int ALU_OP_BUS_W  = 8;
  localparam int ALU_SEL_BUS_W = 3;

  // All-zero opcode/select is the pipeline bubble seen by EX.
  localparam logic [ALU_OP_BUS_W-1:0]  ALUOP_NOP  = '0;
  localparam logic [ALU_SEL_BUS_W-1:0] ALUSEL_NOP = '0;

  function automatic int lane_w(input int aluop_w, input int alusel_w,
                                input int reg_w, input int regaddr_w);
    return aluop_w + alusel_w + 4 * reg_w + regaddr_w + 1;
  endfunction

  // Lanes are packed inside each field (lane1 above lane0); one shared delay-slot bit at the LSB.
  function automatic int payload_w(input int lanes, input int aluop_w, input int alusel_w,
                                   input int reg_w, input int regaddr_w);
    return lanes * lane_w(aluop_w, alusel_w, reg_w, regaddr_w) + 1;
  endfunction

endpackage

// File: rtl/id_ex_slot.sv
// One payload register with valid; clear wins over load and zeroes the payload so nothing stale leaks.
// Latency 1 cycle; no backpressure of its own, the parent decides load/clear.
module id_ex_slot
  import id_ex_elastic_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clear) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/id_ex_elastic.sv
// Elastic ID->EX stage carrying LANES decode slots, with optional skid entry, flush and stall counter.
// Latency 1 cycle; SKID=1 gives a registered id_ready (!skid full), SKID=0 lets id_ready follow EX.
module id_ex_elastic
  import id_ex_elastic_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int ALUOP_W   = ALU_OP_BUS_W,
  parameter int ALUSEL_W  = ALU_SEL_BUS_W,
  parameter int REG_W     = 32,
  parameter int REGADDR_W = 5,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         stall,
  input  logic                         id_valid,
  output logic                         id_ready,
  input  logic [LANES*ALUOP_W-1:0]     id_aluop,
  input  logic [LANES*ALUSEL_W-1:0]    id_alusel,
  input  logic [LANES*REG_W-1:0]       id_reg1,
  input  logic [LANES*REG_W-1:0]       id_reg2,
  input  logic [LANES*REGADDR_W-1:0]   id_wd,
  input  logic [LANES-1:0]             id_wreg,
  input  logic [LANES*REG_W-1:0]       id_link_addr,
  input  logic [LANES*REG_W-1:0]       id_inst,
  input  logic                         id_is_in_delayslot,
  input  logic                         id_next_in_delayslot,
  output logic                         ex_valid,
  input  logic                         ex_ready,
  output logic [LANES*ALUOP_W-1:0]     ex_aluop,
  output logic [LANES*ALUSEL_W-1:0]    ex_alusel,
  output logic [LANES*REG_W-1:0]       ex_reg1,
  output logic [LANES*REG_W-1:0]       ex_reg2,
  output logic [LANES*REGADDR_W-1:0]   ex_wd,
  output logic [LANES-1:0]             ex_wreg,
  output logic [LANES*REG_W-1:0]       ex_link_addr,
  output logic [LANES*REG_W-1:0]       ex_inst,
  output logic                         ex_is_in_delayslot,
  output logic                         is_in_delayslot_o,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int PW = payload_w(LANES, ALUOP_W, ALUSEL_W, REG_W, REGADDR_W);

  logic [PW-1:0] in_dat, main_dat, main_d, skid_dat;
  logic          main_vld, skid_vld, main_load, main_clr;
  logic          drain, accept;

  assign in_dat = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg,
                   id_link_addr, id_inst, id_is_in_delayslot};
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg,
          ex_link_addr, ex_inst, ex_is_in_delayslot} = main_dat;

  assign ex_valid = main_vld;
  assign drain    = main_vld & ex_ready & ~stall;
  assign accept   = id_valid & id_ready;

  // Gated by rst so every output reads zero while reset is held.
  assign id_ready = rst & ((SKID != 0) ? ~skid_vld : (~main_vld | drain));

  // A waiting skid entry always refills main first, preserving order.
  assign main_d    = (drain & skid_vld) ? skid_dat : in_dat;
  assign main_load = (accept & (~main_vld | drain)) | (drain & skid_vld);
  assign main_clr  = flush | (drain & ~main_load);

  id_ex_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .vld   (main_vld),
    .q     (main_dat)
  );

  generate
    if (SKID != 0) begin : g_skid
      id_ex_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (accept & main_vld & ~drain),
        .clear (flush | (drain & skid_vld)),
        .d     (in_dat),
        .vld   (skid_vld),
        .q     (skid_dat)
      );
    end else begin : g_no_skid
      assign skid_vld = 1'b0;
      assign skid_dat = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_in_delayslot_o <= 1'b0;
    end else if (flush) begin
      is_in_delayslot_o <= 1'b0;
    end else if (accept) begin
      is_in_delayslot_o <= id_next_in_delayslot;
    end
  end

  // Perf counter survives flush; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (main_vld & ~(ex_ready & ~stall) & ~(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
